// File: rtl/alu_pkg.sv
// Shared types and constants for the stream ALU engine.
//   state_t   : engine FSM states
//   OP_*      : command opcodes recognised in the first byte of a frame
//   HDR_BYTES : header size (opcode, reserved, len_lsb, len_msb); the length
//               field counts these bytes too
//   is_opcode : true for any of the four recognised opcodes
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RSVD  = 3'd1,
    LEN_L = 3'd2,
    LEN_H = 3'd3,
    ECHO  = 3'd4,
    FOLD  = 3'd5,
    XMIT  = 3'd6
  } state_t;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_SUB  = 8'h5B;
  localparam logic [7:0] OP_XOR  = 8'h5E;

  localparam int HDR_BYTES = 4;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_ECHO) || (b == OP_ADD) || (b == OP_SUB) || (b == OP_XOR);
  endfunction

endpackage

// File: rtl/result_serializer.sv
// Serialises an OPERAND_BYTES-wide result onto an 8-bit AXI-Stream, LSB first.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : 1-cycle pulse, captures acc_i; first byte is valid next cycle
//   acc_i         : result word to send
//   tx_tdata_o    : current byte (0 while idle)
//   tx_tvalid_o   : byte valid
//   tx_tready_i   : downstream accepts byte
//   done_o        : combinational pulse on the handshake of the final byte
module result_serializer #(
  parameter int OPERAND_BYTES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic [8*OPERAND_BYTES-1:0] acc_i,
  output logic [7:0]                 tx_tdata_o,
  output logic                       tx_tvalid_o,
  input  logic                       tx_tready_i,
  output logic                       done_o
);

  localparam int ACC_W = 8 * OPERAND_BYTES;
  localparam int IDX_W = $clog2(OPERAND_BYTES) + 1;

  logic [ACC_W-1:0] data_q;
  logic [IDX_W-1:0] idx_q;
  logic             active_q;
  logic             last_byte;

  assign last_byte   = (idx_q == IDX_W'(OPERAND_BYTES - 1));
  assign tx_tvalid_o = active_q;
  assign done_o      = active_q && tx_tready_i && last_byte;

  // Byte select by index; idle output is forced to zero.
  always_comb begin
    tx_tdata_o = '0;
    for (int i = 0; i < OPERAND_BYTES; i++) begin
      if (active_q && (idx_q == IDX_W'(i))) tx_tdata_o = data_q[i*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      data_q   <= acc_i;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q && tx_tready_i) begin
      if (last_byte) begin
        active_q <= 1'b0;
        idx_q    <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/stream_alu_core.sv
// Packet-level ALU engine between an RX byte stream and a TX byte stream.
// Frame: opcode, reserved, len_lsb, len_msb, payload; len counts the header.
// ECHO streams the payload back; ADD/SUB/XOR fold little-endian operands of
// OPERAND_BYTES and return one OPERAND_BYTES result, LSB first.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   rx_tdata_i/tvalid_i   : input byte stream
//   rx_tready_o           : engine accepts input byte
//   tx_tdata_o/tvalid_o   : output byte stream
//   tx_tready_i           : downstream accepts output byte
//   busy_o                : high whenever the FSM is not IDLE
//   err_o                 : 1-cycle pulse after a header with len < 4
//   dbg_state_o           : current FSM state
//
// Handshake: a byte moves only in a cycle where valid && ready are both high.
// A producer holding valid high keeps its data stable until it is accepted;
// the TX side here honours that (result bytes are registered, echoed bytes are
// the upstream's held data).
module stream_alu_core
  import alu_pkg::*;
#(
  parameter int OPERAND_BYTES = 4,
  parameter int LEN_W         = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_tdata_i,
  input  logic       rx_tvalid_i,
  output logic       rx_tready_o,
  output logic [7:0] tx_tdata_o,
  output logic       tx_tvalid_o,
  input  logic       tx_tready_i,
  output logic       busy_o,
  output logic       err_o,
  output state_t     dbg_state_o
);

  localparam int ACC_W = 8 * OPERAND_BYTES;
  localparam int IDX_W = $clog2(OPERAND_BYTES) + 1;

  state_t           state_q, state_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [7:0]       len_l_q, len_l_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] operand_q, operand_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic             first_q, first_d;
  logic             err_q, err_d;

  logic [LEN_W-1:0] len_full;
  logic [ACC_W-1:0] op_asm;
  logic [ACC_W-1:0] fold_val;
  logic             op_complete;
  logic             last_payload;

  logic             ser_load;
  logic [ACC_W-1:0] ser_acc;
  logic [7:0]       ser_tdata;
  logic             ser_tvalid;
  logic             ser_done;

  assign len_full     = LEN_W'({rx_tdata_i, len_l_q});
  assign last_payload = (remaining_q == LEN_W'(1));
  assign op_complete  = (byte_idx_q == IDX_W'(OPERAND_BYTES - 1)) || last_payload;

  // Operand as it stands including the byte arriving now. Bytes above the
  // current index are zero, so a short trailing operand is zero-extended
  // rather than picking up bytes left over from the previous operand.
  always_comb begin
    op_asm = '0;
    for (int i = 0; i < OPERAND_BYTES; i++) begin
      if (IDX_W'(i) < byte_idx_q)       op_asm[i*8 +: 8] = operand_q[i*8 +: 8];
      else if (IDX_W'(i) == byte_idx_q) op_asm[i*8 +: 8] = rx_tdata_i;
    end
  end

  // Modulo-2^ACC_W fold; SUB seeds the accumulator with its first operand.
  always_comb begin
    fold_val = acc_q;
    case (opcode_q)
      OP_ADD:  fold_val = acc_q + op_asm;
      OP_XOR:  fold_val = acc_q ^ op_asm;
      OP_SUB:  fold_val = first_q ? op_asm : (acc_q - op_asm);
      default: fold_val = acc_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    len_l_d     = len_l_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    operand_d   = operand_q;
    byte_idx_d  = byte_idx_q;
    first_d     = first_q;
    err_d       = 1'b0;
    ser_load    = 1'b0;
    ser_acc     = acc_q;
    rx_tready_o = 1'b1;
    tx_tdata_o  = ser_tdata;
    tx_tvalid_o = ser_tvalid;

    case (state_q)
      IDLE: begin
        if (rx_tvalid_i && is_opcode(rx_tdata_i)) begin
          opcode_d = rx_tdata_i;
          state_d  = RSVD;
        end
      end
      RSVD: begin
        if (rx_tvalid_i) state_d = LEN_L;
      end
      LEN_L: begin
        if (rx_tvalid_i) begin
          len_l_d = rx_tdata_i;
          state_d = LEN_H;
        end
      end
      LEN_H: begin
        if (rx_tvalid_i) begin
          acc_d      = '0;
          operand_d  = '0;
          byte_idx_d = '0;
          first_d    = 1'b1;
          if (len_full < LEN_W'(HDR_BYTES)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            remaining_d = len_full - LEN_W'(HDR_BYTES);
            if (len_full == LEN_W'(HDR_BYTES)) begin
              if (opcode_q == OP_ECHO) begin
                state_d = IDLE;
              end else begin
                // Empty fold still returns a (zero) result.
                ser_load = 1'b1;
                ser_acc  = '0;
                state_d  = XMIT;
              end
            end else begin
              state_d = (opcode_q == OP_ECHO) ? ECHO : FOLD;
            end
          end
        end
      end
      ECHO: begin
        tx_tdata_o  = rx_tdata_i;
        tx_tvalid_o = rx_tvalid_i;
        rx_tready_o = tx_tready_i;
        if (rx_tvalid_i && tx_tready_i) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (last_payload) state_d = IDLE;
        end
      end
      FOLD: begin
        if (rx_tvalid_i) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (op_complete) begin
            acc_d      = fold_val;
            first_d    = 1'b0;
            byte_idx_d = '0;
            operand_d  = '0;
            if (last_payload) begin
              ser_load = 1'b1;
              ser_acc  = fold_val;
              state_d  = XMIT;
            end
          end else begin
            operand_d  = op_asm;
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      XMIT: begin
        rx_tready_o = 1'b0;
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Nothing leaves or enters the engine in a reset cycle.
    if (rst_i) begin
      rx_tready_o = 1'b0;
      tx_tvalid_o = 1'b0;
      tx_tdata_o  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      len_l_q     <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      operand_q   <= '0;
      byte_idx_q  <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      len_l_q     <= len_l_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      operand_q   <= operand_d;
      byte_idx_q  <= byte_idx_d;
      first_q     <= first_d;
      err_q       <= err_d;
    end
  end

  result_serializer #(
    .OPERAND_BYTES(OPERAND_BYTES)
  ) u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (ser_load),
    .acc_i       (ser_acc),
    .tx_tdata_o  (ser_tdata),
    .tx_tvalid_o (ser_tvalid),
    .tx_tready_i (tx_tready_i),
    .done_o      (ser_done)
  );

  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stream_alu_core.sv
module tb_stream_alu_core;
  import alu_pkg::*;

  localparam int OB    = 4;
  localparam int ACC_W = 8 * OB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_tdata = '0;
  logic       rx_tvalid = 1'b0;
  logic       rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready = 1'b1;
  logic       busy;
  logic       err;
  state_t     dbg_state;

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  int vec_cnt = 0;
  int miss_cnt = 0;
  int exp_err = 0;
  int err_cnt = 0;
  int bp_mode = 0;        // 0: always ready, 1: random, 2: stalled
  logic       stall_pend = 1'b0;
  logic [7:0] held_data = '0;

  stream_alu_core #(.OPERAND_BYTES(OB), .LEN_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_tdata_i  (rx_tdata),
    .rx_tvalid_i (rx_tvalid),
    .rx_tready_o (rx_tready),
    .tx_tdata_o  (tx_tdata),
    .tx_tvalid_o (tx_tvalid),
    .tx_tready_i (tx_tready),
    .busy_o      (busy),
    .err_o       (err),
    .dbg_state_o (dbg_state)
  );

  // clock / backpressure
  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    case (bp_mode)
      0:       tx_tready = 1'b1;
      1:       tx_tready = ($urandom_range(0, 3) != 0);
      default: tx_tready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TX monitor: samples on the falling edge, handshake completes next rise.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (err) err_cnt++;
      if (stall_pend) begin
        check("tx_hold_valid", 32'(tx_tvalid), 32'd1);
        check("tx_hold_data", 32'(tx_tdata), 32'(held_data));
      end
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          check("tx_unexpected_byte", 32'(tx_tdata), 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", 32'(tx_tdata), 32'(exp_q.pop_front()));
        end
      end
      stall_pend = tx_tvalid && !tx_tready;
      held_data  = tx_tdata;
    end
  end

  // Reference model: whole-frame arithmetic on pay_q.
  task automatic model_frame(input logic [7:0] op, input int len);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] opv;
    int n;
    if (!(op == OP_ECHO || op == OP_ADD || op == OP_SUB || op == OP_XOR)) return;
    if (len < 4) begin
      exp_err++;
      return;
    end
    n = len - 4;
    if (op == OP_ECHO) begin
      for (int i = 0; i < n; i++) exp_q.push_back(pay_q[i]);
      return;
    end
    acc = '0;
    for (int c = 0; c * OB < n; c++) begin
      opv = '0;
      for (int k = 0; k < OB && (c * OB + k) < n; k++)
        opv = opv | (ACC_W'(pay_q[c * OB + k]) << (8 * k));
      if (op == OP_ADD)      acc = acc + opv;
      else if (op == OP_XOR) acc = acc ^ opv;
      else                   acc = (c == 0) ? opv : acc - opv;
    end
    for (int i = 0; i < OB; i++) exp_q.push_back(8'(acc >> (8 * i)));
  endtask

  // driver tasks: called and return at posedge + 1
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_tready) break;
      t++;
      if (t > 2000) begin
        check("rx_accept_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
  endtask

  task automatic send_raw(input logic [7:0] op, input logic [15:0] len, input bit gaps);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (pay_q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(pay_q[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] len, input bit gaps);
    model_frame(op, int'(len));
    send_raw(op, len, gaps);
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (2) @(negedge clk);
    while ((exp_q.size() != 0 || busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", 32'(t < 2000), 32'd1);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("err_pulses", 32'(err_cnt), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_rx_tready", 32'(rx_tready), 32'd1);
    check("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
    check("rst_tx_tdata", 32'(tx_tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $error("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int plen, op_sel, len;
    logic [7:0] op;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs();

    // ADD, with first-result latency
    bp_mode = 0;
    pay_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_frame(OP_ADD, 16'd12, 1'b0);
    @(negedge clk);
    check("add_first_byte_latency", 32'(tx_tvalid), 32'd1);
    wait_idle();

    // ECHO with a 5-cycle stall mid-stream
    pay_q = '{8'h41, 8'h42, 8'h43};
    model_frame(OP_ECHO, 7);
    send_byte(OP_ECHO);
    send_byte(8'h00);
    send_byte(8'h07);
    send_byte(8'h00);
    send_byte(8'h41);
    bp_mode   = 2;
    rx_tdata  = 8'h42;
    rx_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("echo_stall_rx_tready", 32'(rx_tready), 32'd0);
    end
    @(posedge clk);
    #1;
    bp_mode = 0;
    send_byte(8'h42);
    send_byte(8'h43);
    wait_idle();

    // SUB wrap, random backpressure from here on
    bp_mode = 1;
    pay_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_frame(OP_SUB, 16'd12, 1'b0);
    wait_idle();

    // trailing partial operand
    pay_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02};
    send_frame(OP_ADD, 16'd10, 1'b0);
    wait_idle();

    // unknown byte dropped, short length flagged, then a one-byte echo
    send_byte(8'h77);
    pay_q.delete();
    send_frame(OP_ADD, 16'd2, 1'b0);
    wait_idle();
    pay_q = '{8'h99};
    send_frame(OP_ECHO, 16'd5, 1'b0);
    wait_idle();

    // reset in the middle of a fold
    pay_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    send_raw(OP_ADD, 16'd12, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs();
    pay_q = '{8'h05, 8'h00, 8'h00, 8'h00};
    send_frame(OP_ADD, 16'd8, 1'b0);
    wait_idle();

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      op_sel = $urandom_range(0, 3);
      op = (op_sel == 0) ? OP_ECHO : (op_sel == 1) ? OP_ADD : (op_sel == 2) ? OP_SUB : OP_XOR;
      bp_mode = $urandom_range(0, 1);
      pay_q.delete();
      if ($urandom_range(0, 7) == 0) begin
        len = $urandom_range(0, 3);
      end else begin
        plen = $urandom_range(0, 13);
        for (int i = 0; i < plen; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        len = plen + 4;
      end
      send_frame(op, 16'(len), 1'b1);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
